// File: rtl/phy_init_pkg.sv
// Shared definitions for the PHY strap/reset power-up sequencer.
package phy_init_pkg;

  typedef enum logic [2:0] {
    START,
    ASSERT_RST,
    HOLD,
    SETTLE,
    READY
  } state_t;

  // Counter width large enough to hold (longest window - 1); never narrower than one bit
  function automatic int cnt_w(input int rst_cycles, input int hold_cycles,
                               input int settle_cycles);
    int longest;
    longest = rst_cycles;
    if (hold_cycles > longest) longest = hold_cycles;
    if (settle_cycles > longest) longest = settle_cycles;
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/phy_init_timer.sv
// Loadable down-counter shared by all sequencer windows. Loading N-1 and
// leaving the state when zero reads true gives a window of exactly N cycles.
module phy_init_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phy_strap_init.sv
// Power-up sequencer for NUM_PHY Ethernet PHYs: latches straps, pulses the
// hardware reset, holds straps after release, waits for settle, then flags
// ready. Any subset of PHYs can be re-sequenced later while the rest keep
// running undisturbed.
module phy_strap_init
  import phy_init_pkg::*;
#(
  parameter int NUM_PHY       = 2,
  parameter int STRAP_W       = 10,
  parameter int RST_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 5000,
  parameter int SETTLE_CYCLES = 5000
) (
  input  logic                       clk_50,
  input  logic                       reset_n,
  input  logic [NUM_PHY*STRAP_W-1:0] strap_value,
  output logic [NUM_PHY*STRAP_W-1:0] strap_out,
  output logic [NUM_PHY-1:0]         strap_oe,
  output logic [NUM_PHY-1:0]         phy_rst_n,
  input  logic                       reinit_req,
  input  logic [NUM_PHY-1:0]         reinit_mask,
  output logic                       busy,
  output logic [NUM_PHY-1:0]         phy_ready
);

  localparam int CNT_W = cnt_w(RST_CYCLES, HOLD_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [NUM_PHY-1:0] sel;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               timer_zero;

  phy_init_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .zero    (timer_zero)
  );

  // Reload the timer on the edge that enters the next timed window
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      START: begin
        timer_load  = 1'b1;
        timer_value = RST_LOAD;
      end
      ASSERT_RST: begin
        timer_load  = timer_zero;
        timer_value = HOLD_LOAD;
      end
      HOLD: begin
        timer_load  = timer_zero;
        timer_value = SETTLE_LOAD;
      end
      SETTLE: begin
        timer_load  = timer_zero;
        timer_value = '0;
      end
      default: begin
        timer_load  = 1'b0;
        timer_value = '0;
      end
    endcase
  end

  // Sequencer FSM; only PHYs in sel are touched, others keep their outputs
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= START;
      sel       <= '1;
      phy_rst_n <= '0;
      strap_oe  <= '0;
      strap_out <= '0;
      phy_ready <= '0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        START: begin
          for (int i = 0; i < NUM_PHY; i++) begin
            if (sel[i]) begin
              strap_out[i*STRAP_W +: STRAP_W] <= strap_value[i*STRAP_W +: STRAP_W];
              strap_oe[i]  <= 1'b1;
              phy_rst_n[i] <= 1'b0;
              phy_ready[i] <= 1'b0;
            end
          end
          state <= ASSERT_RST;
        end
        ASSERT_RST: begin
          if (timer_zero) begin
            phy_rst_n <= phy_rst_n | sel;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (timer_zero) begin
            strap_oe <= strap_oe & ~sel;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            phy_ready <= phy_ready | sel;
            busy      <= 1'b0;
            state     <= READY;
          end
        end
        READY: begin
          if (reinit_req && (reinit_mask != '0)) begin
            sel   <= reinit_mask;
            busy  <= 1'b1;
            state <= START;
          end
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_strap_init.sv
// Self-checking bench for phy_strap_init. A timeline model (edges elapsed
// since START) predicts every output each cycle; fixed tables and hand
// sequences pin down the documented edge numbers.
module tb_phy_strap_init;

  localparam int NUM_PHY       = 2;
  localparam int STRAP_W       = 10;
  localparam int RST_CYCLES    = 8;
  localparam int HOLD_CYCLES   = 4;
  localparam int SETTLE_CYCLES = 6;
  localparam int SW            = NUM_PHY * STRAP_W;
  localparam int DONE_T        = RST_CYCLES + HOLD_CYCLES + SETTLE_CYCLES;

  logic               clk_50;
  logic               reset_n;
  logic [SW-1:0]      strap_value;
  logic [SW-1:0]      strap_out;
  logic [NUM_PHY-1:0] strap_oe;
  logic [NUM_PHY-1:0] phy_rst_n;
  logic               reinit_req;
  logic [NUM_PHY-1:0] reinit_mask;
  logic               busy;
  logic [NUM_PHY-1:0] phy_ready;

  int errCount   = 0;
  int checkCount = 0;
  int edgeCnt    = 0;

  // Reference model state: mT = -1 means the next edge is a START edge
  int                 mT;
  logic [NUM_PHY-1:0] mSel;
  logic [NUM_PHY-1:0] mOe;
  logic [NUM_PHY-1:0] mRstN;
  logic [NUM_PHY-1:0] mReady;
  logic [SW-1:0]      mStrap;
  logic               mBusy;

  typedef struct {
    int                 edgeN;
    logic [SW-1:0]      strap;
    logic [NUM_PHY-1:0] oe;
    logic [NUM_PHY-1:0] rstN;
    logic [NUM_PHY-1:0] ready;
    logic               bsy;
  } vec_t;

  vec_t vecs[7];

  phy_strap_init #(
    .NUM_PHY       (NUM_PHY),
    .STRAP_W       (STRAP_W),
    .RST_CYCLES    (RST_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .strap_value (strap_value),
    .strap_out   (strap_out),
    .strap_oe    (strap_oe),
    .phy_rst_n   (phy_rst_n),
    .reinit_req  (reinit_req),
    .reinit_mask (reinit_mask),
    .busy        (busy),
    .phy_ready   (phy_ready)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic modelReset();
    mT     = -1;
    mSel   = '1;
    mOe    = '0;
    mRstN  = '0;
    mReady = '0;
    mStrap = '0;
    mBusy  = 1'b1;
  endtask

  // Outputs of a selected PHY are a pure function of edges since START
  task automatic modelEdge(input logic req, input logic [NUM_PHY-1:0] mask,
                           input logic [SW-1:0] sv);
    if (mT == -1) begin
      mT = 0;
      for (int i = 0; i < NUM_PHY; i++)
        if (mSel[i]) mStrap[i*STRAP_W +: STRAP_W] = sv[i*STRAP_W +: STRAP_W];
    end else if (mT < DONE_T) begin
      mT++;
    end else if (req && (mask != '0)) begin
      mT   = -1;
      mSel = mask;
    end
    if (mT >= 0) begin
      for (int i = 0; i < NUM_PHY; i++) begin
        if (mSel[i]) begin
          mOe[i]    = (mT < RST_CYCLES + HOLD_CYCLES);
          mRstN[i]  = (mT >= RST_CYCLES);
          mReady[i] = (mT >= DONE_T);
        end
      end
    end
    mBusy = (mT != DONE_T);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".strap_out"}, 32'(strap_out), 32'(mStrap));
    checkVal({tag, ".strap_oe"},  32'(strap_oe),  32'(mOe));
    checkVal({tag, ".phy_rst_n"}, 32'(phy_rst_n), 32'(mRstN));
    checkVal({tag, ".phy_ready"}, 32'(phy_ready), 32'(mReady));
    checkVal({tag, ".busy"},      32'(busy),      32'(mBusy));
  endtask

  // Drive inputs just after an edge, clock once, then check against the model
  task automatic applyStimulus(input logic req, input logic [NUM_PHY-1:0] mask,
                               input logic [SW-1:0] sv, input string tag);
    reinit_req  = req;
    reinit_mask = mask;
    strap_value = sv;
    @(posedge clk_50);
    if (reset_n) modelEdge(req, mask, sv);
    edgeCnt++;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [SW-1:0] pwrV;
    logic [SW-1:0] newV;
    logic [SW-1:0] capV;
    logic [SW-1:0] rv;
    logic [NUM_PHY-1:0] rm;
    logic rq;

    pwrV = {10'h155, 10'h2AA};
    newV = {10'h0F0, 10'h3FF};

    vecs[0] = '{1,  pwrV, 2'b11, 2'b00, 2'b00, 1'b1};
    vecs[1] = '{8,  pwrV, 2'b11, 2'b00, 2'b00, 1'b1};
    vecs[2] = '{9,  pwrV, 2'b11, 2'b11, 2'b00, 1'b1};
    vecs[3] = '{12, pwrV, 2'b11, 2'b11, 2'b00, 1'b1};
    vecs[4] = '{13, pwrV, 2'b00, 2'b11, 2'b00, 1'b1};
    vecs[5] = '{18, pwrV, 2'b00, 2'b11, 2'b00, 1'b1};
    vecs[6] = '{19, pwrV, 2'b00, 2'b11, 2'b11, 1'b0};

    // Reset state
    reset_n     = 1'b0;
    reinit_req  = 1'b0;
    reinit_mask = '0;
    strap_value = pwrV;
    modelReset();
    #12;
    checkVal("rst.strap_out", 32'(strap_out), 32'h0);
    checkVal("rst.strap_oe",  32'(strap_oe),  32'h0);
    checkVal("rst.phy_rst_n", 32'(phy_rst_n), 32'h0);
    checkVal("rst.phy_ready", 32'(phy_ready), 32'h0);
    checkVal("rst.busy",      32'(busy),      32'h1);
    reset_n = 1'b1;
    edgeCnt = 0;

    // Power-up timeline against fixed edge numbers
    for (int v = 0; v < 7; v++) begin
      while (edgeCnt < vecs[v].edgeN) applyStimulus(1'b0, '0, pwrV, "pwr");
      checkVal($sformatf("vec%0d.strap_out", v), 32'(strap_out), 32'(vecs[v].strap));
      checkVal($sformatf("vec%0d.strap_oe", v),  32'(strap_oe),  32'(vecs[v].oe));
      checkVal($sformatf("vec%0d.phy_rst_n", v), 32'(phy_rst_n), 32'(vecs[v].rstN));
      checkVal($sformatf("vec%0d.phy_ready", v), 32'(phy_ready), 32'(vecs[v].ready));
      checkVal($sformatf("vec%0d.busy", v),      32'(busy),      32'(vecs[v].bsy));
    end

    // Selective re-init of PHY1 only
    applyStimulus(1'b1, 2'b10, newV, "reinit_req");
    applyStimulus(1'b0, 2'b00, newV, "reinit_start");
    checkVal("reinit.strap1",    32'(strap_out[19:10]), 32'h0F0);
    checkVal("reinit.strap0",    32'(strap_out[9:0]),   32'h2AA);
    checkVal("reinit.phy_ready", 32'(phy_ready),        32'h1);
    checkVal("reinit.phy_rst_n", 32'(phy_rst_n),        32'h1);
    checkVal("reinit.strap_oe",  32'(strap_oe),         32'h2);
    for (int k = 0; k < DONE_T - 1; k++) applyStimulus(1'b0, '0, newV, "reinit_run");
    checkVal("reinit_pre.phy_ready", 32'(phy_ready), 32'h1);
    applyStimulus(1'b0, '0, newV, "reinit_done");
    checkVal("reinit_done.phy_ready", 32'(phy_ready), 32'h3);
    checkVal("reinit_done.busy",      32'(busy),      32'h0);

    // Requests while busy or with an empty mask are ignored
    applyStimulus(1'b1, 2'b01, pwrV, "ign_req");
    applyStimulus(1'b0, '0, pwrV, "ign_start");
    for (int k = 0; k < RST_CYCLES + 1; k++) applyStimulus(1'b0, '0, pwrV, "ign_run");
    applyStimulus(1'b1, 2'b11, newV, "ign_hold_req");
    checkVal("ign_hold.busy",      32'(busy),      32'h1);
    checkVal("ign_hold.phy_ready", 32'(phy_ready), 32'h2);
    for (int k = 0; k < DONE_T - RST_CYCLES - 2; k++) applyStimulus(1'b0, '0, newV, "ign_run2");
    checkVal("ign_done.phy_ready", 32'(phy_ready), 32'h3);
    applyStimulus(1'b1, 2'b00, newV, "ign_zero_mask");
    applyStimulus(1'b0, 2'b00, newV, "ign_after");
    checkVal("ign_zero.busy",      32'(busy),      32'h0);
    checkVal("ign_zero.phy_ready", 32'(phy_ready), 32'h3);

    // Async reset in the middle of HOLD, then a full sequence with toggling straps
    applyStimulus(1'b1, 2'b11, pwrV, "ar_req");
    for (int k = 0; k < RST_CYCLES + 2; k++) applyStimulus(1'b0, '0, pwrV, "ar_run");
    reset_n = 1'b0;
    #1;
    modelReset();
    checkVal("ar.phy_rst_n", 32'(phy_rst_n), 32'h0);
    checkVal("ar.strap_oe",  32'(strap_oe),  32'h0);
    checkVal("ar.phy_ready", 32'(phy_ready), 32'h0);
    checkVal("ar.busy",      32'(busy),      32'h1);
    applyStimulus(1'b0, '0, pwrV, "ar_low");
    reset_n = 1'b1;
    edgeCnt = 0;
    capV = SW'($urandom);
    applyStimulus(1'b0, '0, capV, "tog_start");
    while (edgeCnt < DONE_T) applyStimulus(1'b0, '0, SW'($urandom), "tog_run");
    checkVal("tog_pre.phy_ready", 32'(phy_ready), 32'h0);
    applyStimulus(1'b0, '0, SW'($urandom), "tog_done");
    checkVal("tog.strap_out", 32'(strap_out), 32'(capV));
    checkVal("tog.phy_ready", 32'(phy_ready), 32'h3);

    // Randomized traffic against the timeline model
    for (int n = 0; n < 800; n++) begin
      rq = ($urandom_range(0, 5) == 0);
      rm = NUM_PHY'($urandom);
      rv = SW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rand_async");
        applyStimulus(rq, rm, rv, "rand_rst");
        reset_n = 1'b1;
      end else begin
        applyStimulus(rq, rm, rv, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/phy_strap_init.md
Name: phy_strap_init

Overview:
Parametrised PHY power-up sequencer for NUM_PHY external Ethernet PHYs that share one sequencer. It drives configurable strap values onto the PHY strap pins and pulses a hardware reset. It keeps the straps driven for a hold window after reset release, waits a settle window before MIIM access, and then reports ready per PHY. Unlike the single-PHY fixed-strap predecessor, it supports selective re-initialisation of any subset of PHYs at run time. It sits between the top level (which builds tristate pads from strap_out/strap_oe) and the MIIM/MAC logic.

Parameters:
NUM_PHY, 2, number of PHYs sequenced
STRAP_W, 10, strap bits per PHY (mode, clk125 enable, address, ...)
RST_CYCLES, 500000, phy_rst_n low time in clk_50 cycles (10 ms at 50 MHz); must be >=1
HOLD_CYCLES, 5000, straps held after reset release (100 us); must be >=1
SETTLE_CYCLES, 5000, wait after strap release before ready (100 us); must be >=1

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
strap_value  in  NUM_PHY*STRAP_W  strap word per PHY, PHY i at [i*STRAP_W +: STRAP_W]
strap_out  out  NUM_PHY*STRAP_W  latched strap values to pads
strap_oe  out  NUM_PHY  pad output enable per PHY (1 = drive strap_out)
phy_rst_n  out  NUM_PHY  active-low hardware reset per PHY
reinit_req  in  1  single-cycle request to re-initialise PHYs in reinit_mask
reinit_mask  in  NUM_PHY  PHY select, sampled with reinit_req
busy  out  1  sequence in progress
phy_ready  out  NUM_PHY  PHY i configured and MIIM-accessible

Behaviour:
- Async reset values: state=START, sel=all ones, phy_rst_n=all 0, strap_oe=0, strap_out=0, phy_ready=0, busy=1, counter=0.
- One shared down-counter; load N-1 on state entry; leave the state on the cycle the counter reads 0 (state duration exactly N cycles).
- START (1 cycle): for each PHY i with sel[i]=1, latch strap_value slice into strap_out, set strap_oe[i]=1, phy_rst_n[i]=0, phy_ready[i]=0 -> ASSERT_RST.
- ASSERT_RST (RST_CYCLES): hold outputs; on terminal count set phy_rst_n[i]=1 for selected PHYs -> HOLD.
- HOLD (HOLD_CYCLES): straps still driven; on terminal count clear strap_oe for selected PHYs -> SETTLE.
- SETTLE (SETTLE_CYCLES): on terminal count set phy_ready[i]=1 for selected PHYs, busy=0 -> READY.
- READY: reinit_req=1 with reinit_mask!=0 -> sel<=reinit_mask, busy<=1 -> START next cycle. In the START cycle the selected PHYs are reset and drop ready; unselected PHYs keep phy_ready, phy_rst_n=1, strap_oe=0 and strap_out unchanged.
- reinit_req with reinit_mask=0 is ignored. reinit_req while busy=1 is ignored (not queued).
- strap_value is sampled only in START; changes later in the sequence have no effect until the next START.
- reset_n low at any time returns to the reset values immediately (all PHYs into reset, ready cleared); the full sequence restarts on the first clock edge after deassertion.
- From reset_n rising, phy_ready goes high 1+RST_CYCLES+HOLD_CYCLES+SETTLE_CYCLES edges later.
- All outputs registered; no combinational input-to-output paths.

Decomposition:
- Package phy_init_pkg: state enum (START, ASSERT_RST, HOLD, SETTLE, READY), and a cnt_w function using $clog2 of the largest of RST_CYCLES, HOLD_CYCLES and SETTLE_CYCLES.
- Sub-module phy_init_timer: loadable down-counter with a load input, a value input and a zero flag. It is instantiated once in the sequencer.

Test Plan:
- Power-up with NUM_PHY=2, STRAP_W=10, RST=8, HOLD=4, SETTLE=6, strap_value=0x155_2AA -> strap_out=0x155_2AA and strap_oe=2'b11 from edge 1; phy_rst_n=2'b11 at edge 9; strap_oe=0 at edge 13; phy_ready=2'b11 and busy=0 at edge 19.
- In READY, reinit_req with mask=2'b10 and new strap_value=0x0F0_3FF -> only PHY1 resets and its strap_out becomes 0x0F0; PHY0 strap_out stays 0x2AA and phy_ready[0] stays 1 throughout; phy_ready returns to 2'b11 19 cycles after START.
- reinit_req pulsed during HOLD, and again with mask=0 in READY -> no state change; busy and phy_ready unaffected.
- reset_n asserted mid-HOLD -> phy_rst_n=0, strap_oe=0, phy_ready=0 asynchronously; full 19-cycle sequence repeats after release.
- Toggle strap_value every cycle during ASSERT_RST -> strap_out holds the value sampled in START.
